// File: rtl/spi_reg_master.sv
// Mode-0 SPI initiator for 6-bit-addressed, 32-bit register read/write frames.
// Frame: 16-bit header, optional read gap, then 8/16/32 data bits, MSB first.
module spi_reg_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned READ_GAP = 8,
  parameter int unsigned CS_GUARD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [1:0]  cmd_width,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned BIT_W = 7;
  localparam int unsigned CNT_W = ($clog2(CLK_DIV + 1) > $clog2(CS_GUARD + 1)) ?
                                  $clog2(CLK_DIV + 1) : $clog2(CS_GUARD + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((CS_GUARD > 0) ? CS_GUARD - 1 : 0);
  localparam logic [BIT_W-1:0] GAP        = BIT_W'(READ_GAP);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nx;
  logic             rw_q, rw_nx;
  logic [1:0]       wn_q, wn_nx;
  logic [5:0]       addr_q, addr_nx;
  logic [31:0]      wdata_q, wdata_nx;
  logic [31:0]      rx_q, rx_nx;
  logic             cmd_ready_nx, rsp_valid_nx, busy_nx;
  logic             cs_n_nx, sclk_nx, mosi_nx;
  logic [31:0]      rdata_nx;

  logic [1:0]       cmd_wn;
  logic [BIT_W-1:0] cmd_n, cmd_last;
  logic [BIT_W-1:0] n_bits, gap_bits, hdr_base, idx;
  logic [15:0]      header;
  logic             tx_next;

  // Frame geometry for the command being offered and for the latched one
  assign cmd_wn   = (cmd_width == 2'b11) ? 2'b10 : cmd_width;
  assign cmd_n    = BIT_W'(8) << cmd_wn;
  assign cmd_last = BIT_W'(15) + cmd_n + (cmd_rw ? BIT_W'(0) : GAP);
  assign n_bits   = BIT_W'(8) << wn_q;
  assign gap_bits = rw_q ? BIT_W'(0) : GAP;
  assign header   = {rw_q, 5'b0, wn_q, 2'b0, addr_q};

  // MOSI value for the bit that follows the current one (bit_cnt counts down to 0)
  always_comb begin
    idx      = bit_cnt - BIT_W'(1);
    hdr_base = n_bits + gap_bits;
    tx_next  = 1'b0;
    if (idx >= hdr_base) begin
      tx_next = header[4'(idx - hdr_base)];
    end else if (idx < n_bits) begin
      tx_next = rw_q & wdata_q[5'(idx)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      rw_q      <= 1'b0;
      wn_q      <= 2'b00;
      addr_q    <= 6'd0;
      wdata_q   <= 32'd0;
      rx_q      <= 32'd0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      busy      <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      rw_q      <= rw_nx;
      wn_q      <= wn_nx;
      addr_q    <= addr_nx;
      wdata_q   <= wdata_nx;
      rx_q      <= rx_nx;
      cmd_ready <= cmd_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rdata_nx;
      busy      <= busy_nx;
      spi_cs_n  <= cs_n_nx;
      spi_clk   <= sclk_nx;
      spi_mosi  <= mosi_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    bit_cnt_nx   = bit_cnt;
    rw_nx        = rw_q;
    wn_nx        = wn_q;
    addr_nx      = addr_q;
    wdata_nx     = wdata_q;
    rx_nx        = rx_q;
    cmd_ready_nx = cmd_ready;
    rsp_valid_nx = 1'b0;
    rdata_nx     = rsp_rdata;
    busy_nx      = busy;
    cs_n_nx      = spi_cs_n;
    sclk_nx      = spi_clk;
    mosi_nx      = spi_mosi;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          rw_nx        = cmd_rw;
          wn_nx        = cmd_wn;
          addr_nx      = cmd_addr;
          wdata_nx     = cmd_wdata;
          rx_nx        = 32'd0;
          bit_cnt_nx   = cmd_last;
          cnt_nx       = '0;
          cmd_ready_nx = 1'b0;
          busy_nx      = 1'b1;
          cs_n_nx      = 1'b0;
          mosi_nx      = cmd_rw;
          state_nx     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt == GUARD_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_SHIFT;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      // Each SCLK phase lasts CLK_DIV cycles; the first phase is low
      ST_SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_nx = '0;
          if (!spi_clk) begin
            sclk_nx = 1'b1;
            if (bit_cnt < n_bits) begin
              rx_nx = {rx_q[30:0], spi_miso};
            end
          end else begin
            sclk_nx = 1'b0;
            if (bit_cnt == '0) begin
              mosi_nx  = 1'b0;
              state_nx = ST_HOLD;
            end else begin
              bit_cnt_nx = bit_cnt - BIT_W'(1);
              mosi_nx    = tx_next;
            end
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt == GUARD_LAST) begin
          cnt_nx       = '0;
          cs_n_nx      = 1'b1;
          rsp_valid_nx = 1'b1;
          rdata_nx     = rw_q ? 32'd0 : rx_q;
          state_nx     = ST_DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        busy_nx      = 1'b0;
        cmd_ready_nx = 1'b1;
        state_nx     = ST_IDLE;
      end

      default: begin
        cmd_ready_nx = 1'b1;
        busy_nx      = 1'b0;
        cs_n_nx      = 1'b1;
        sclk_nx      = 1'b0;
        mosi_nx      = 1'b0;
        state_nx     = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: table vectors, corner sequences and random traffic
// checked against a frame-level model with an emulated SPI slave.
module tb_spi_reg_master;

  localparam int CLK_DIV  = 4;
  localparam int READ_GAP = 8;
  localparam int CS_GUARD = 4;
  localparam int TMO      = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [1:0]  cmd_width;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, busy, spi_cs_n, spi_clk, spi_mosi, spi_miso;
  logic [31:0] rsp_rdata;

  spi_reg_master #(.CLK_DIV(CLK_DIV), .READ_GAP(READ_GAP), .CS_GUARD(CS_GUARD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_width(cmd_width), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Slave emulation / observation state
  bit          miso_bits [128];
  int          rise_cnt = 0, cs_low = 0, rsp_cnt = 0, high_run = 0, last_gap = 0, mosi_viol = 0;
  logic [127:0] mosi_acc = '0;
  bit          prev_sclk = 1'b0, prev_cs = 1'b1;
  logic        prev_mosi = 1'b0;

  typedef struct {
    logic        rw;
    logic [1:0]  width;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] miso_word;
    logic [15:0] exp_hdr;
    int          exp_pulses;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic int n_of(input logic [1:0] w);
    return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] mask_of(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [15:0] hdr_of(input logic rw, input logic [1:0] w, input logic [5:0] a);
    logic [1:0] wt;
    wt = (w == 2'b11) ? 2'b10 : w;
    return {rw, 5'b0, wt, 2'b0, a};
  endfunction

  // Slave response: garbage everywhere except the read data phase
  task automatic set_miso(input logic rw, input int n, input logic [31:0] word);
    for (int p = 0; p < 128; p++) miso_bits[p] = 1'($urandom);
    if (!rw)
      for (int i = 0; i < n; i++) miso_bits[16 + READ_GAP + i] = word[n - 1 - i];
  endtask

  // Observer and MISO driver, sampling on the falling clk edge
  initial begin
    forever begin
      @(negedge clk);
      if (spi_cs_n === 1'b1) high_run++;
      else if (spi_cs_n === 1'b0) begin
        if (prev_cs) begin
          last_gap = high_run;
          rise_cnt = 0;
          spi_miso = miso_bits[0];
        end
        high_run = 0;
        cs_low++;
      end
      if (spi_clk === 1'b1 && !prev_sclk) begin
        mosi_acc = {mosi_acc[126:0], spi_mosi};
        rise_cnt++;
      end
      if (spi_clk === 1'b0 && prev_sclk) spi_miso = miso_bits[rise_cnt];
      if (spi_clk === 1'b1 && prev_sclk && spi_mosi !== prev_mosi) mosi_viol++;
      if (rsp_valid === 1'b1) rsp_cnt++;
      prev_sclk = (spi_clk === 1'b1);
      prev_cs   = (spi_cs_n !== 1'b0);
      prev_mosi = spi_mosi;
    end
  end

  task automatic clear_obs();
    rise_cnt = 0; mosi_acc = '0; cs_low = 0; rsp_cnt = 0;
  endtask

  // Offer a command at a negedge, wait for acceptance, then scramble the fields
  task automatic offer(input logic rw, input logic [1:0] w, input logic [5:0] a,
                       input logic [31:0] d, input string nm, output bit ok);
    int tmo;
    tmo = 0;
    cmd_rw = rw; cmd_width = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && tmo < TMO) begin @(negedge clk); tmo++; end
    total++;
    if (tmo < TMO) passed++;
    else $display("FAIL %s accept: got no cmd_ready expected cmd_ready within %0d cycles", nm, TMO);
    ok = (tmo < TMO);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rw = 1'($urandom); cmd_width = 2'($urandom); cmd_addr = 6'($urandom); cmd_wdata = $urandom;
  endtask

  task automatic run_txn(input logic rw, input logic [1:0] w, input logic [5:0] a,
                         input logic [31:0] d, input logic [31:0] word, input logic [15:0] ehdr,
                         input int epulses, input logic [31:0] erd, input string nm);
    int n, gap, tmo, elow;
    bit ok;
    logic [127:0] es, got;
    n = n_of(w);
    gap = rw ? 0 : READ_GAP;
    set_miso(rw, n, word);
    @(negedge clk);
    clear_obs();
    offer(rw, w, a, d, nm, ok);
    if (!ok) return;
    tmo = 0;
    while (rsp_valid !== 1'b1 && tmo < TMO) begin @(negedge clk); tmo++; end
    if (tmo >= TMO) begin
      total++;
      $display("FAIL %s rsp: got no rsp_valid expected rsp_valid within %0d cycles", nm, TMO);
      return;
    end
    chk({nm, " rdata"}, 128'(rsp_rdata), 128'(erd));
    chk({nm, " busy_at_rsp"}, 128'(busy), 128'(1));
    @(negedge clk);
    chk({nm, " after_rsp v/busy/ready/cs"}, 128'({rsp_valid, busy, cmd_ready, spi_cs_n}), 128'(4'b0011));
    chk({nm, " pulses"}, 128'(rise_cnt), 128'(epulses));
    es = 128'(ehdr);
    es = es << gap;
    es = es << n;
    if (rw) es = es | 128'(d & mask_of(n));
    got = mosi_acc;
    if (!rw) begin got = got >> n; es = es >> n; end
    chk({nm, " mosi"}, got, es);
    elow = 2 * CS_GUARD + 2 * epulses * CLK_DIV;
    total++;
    if (cs_low >= elow - 2 && cs_low <= elow + 2) passed++;
    else $display("FAIL %s cs_low_time: got %0d expected %0d +-2", nm, cs_low, elow);
    chk({nm, " rsp_count"}, 128'(rsp_cnt), 128'(1));
    repeat (3) @(negedge clk);
    chk({nm, " rdata_hold"}, 128'(rsp_rdata), 128'(erd));
  endtask

  initial begin
    bit ok;
    int tmo, viol, ready_lag;
    bit seen_rsp;

    tbl[0] = '{1'b1, 2'b00, 6'h05, 32'h0000_00A5, 32'h0, 16'h8005, 24, 32'h0, "w8_a05"};
    tbl[1] = '{1'b1, 2'b10, 6'h3F, 32'hDEAD_BEEF, 32'h0, 16'h823F, 48, 32'h0, "w32_a3f"};
    tbl[2] = '{1'b0, 2'b01, 6'h01, 32'h0, 32'h0000_1234, 16'h0101, 40, 32'h0000_1234, "r16_a01"};
    tbl[3] = '{1'b0, 2'b11, 6'h02, 32'h0, 32'hCAFE_F00D, 16'h0202, 56, 32'hCAFE_F00D, "r11_a02"};
    tbl[4] = '{1'b0, 2'b00, 6'h2A, 32'h0, 32'hFFFF_FF5C, 16'h002A, 32, 32'h0000_005C, "r8_a2a"};
    tbl[5] = '{1'b1, 2'b01, 6'h10, 32'hFFFF_1234, 32'h0, 16'h8110, 32, 32'h0, "w16_a10"};

    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_width = 2'b00; cmd_addr = 6'd0;
    cmd_wdata = 32'd0; spi_miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 128'({cmd_ready, rsp_valid, busy, spi_cs_n, spi_clk, spi_mosi}), 128'(6'b100100));
    chk("reset rdata", 128'(rsp_rdata), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].rw, tbl[i].width, tbl[i].addr, tbl[i].wdata, tbl[i].miso_word,
              tbl[i].exp_hdr, tbl[i].exp_pulses, tbl[i].exp_rdata, tbl[i].name);

    // Back-to-back with cmd_valid held: read then write
    set_miso(1'b0, 8, 32'h0000_003C);
    @(negedge clk);
    clear_obs();
    cmd_rw = 1'b0; cmd_width = 2'b00; cmd_addr = 6'h11; cmd_wdata = 32'd0; cmd_valid = 1'b1;
    tmo = 0;
    while (cmd_ready !== 1'b1 && tmo < TMO) begin @(negedge clk); tmo++; end
    @(negedge clk);
    cmd_rw = 1'b1; cmd_width = 2'b00; cmd_addr = 6'h22; cmd_wdata = 32'h0000_0077;
    viol = 0; seen_rsp = 1'b0; ready_lag = 0; tmo = 0;
    while (!(seen_rsp && cmd_ready === 1'b1) && tmo < TMO) begin
      if (busy === 1'b1 && cmd_ready === 1'b1) viol++;
      if (rsp_valid === 1'b1) begin
        seen_rsp = 1'b1;
        chk("b2b first rdata", 128'(rsp_rdata), 128'(32'h3C));
        chk("b2b ready_at_rsp", 128'(cmd_ready), 128'(0));
      end else if (seen_rsp) ready_lag++;
      @(negedge clk);
      tmo++;
    end
    chk("b2b second accept_seen", 128'(seen_rsp && cmd_ready === 1'b1), 128'(1));
    chk("b2b ready_lag", 128'(ready_lag), 128'(0));
    @(negedge clk);
    chk("b2b ready_pulse", 128'(cmd_ready), 128'(0));
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0000_00FF;
    clear_obs();
    tmo = 0;
    while (rsp_valid !== 1'b1 && tmo < TMO) begin
      if (busy === 1'b1 && cmd_ready === 1'b1) viol++;
      @(negedge clk); tmo++;
    end
    chk("b2b second rsp_seen", 128'(rsp_valid), 128'(1));
    chk("b2b ready_while_busy", 128'(viol), 128'(0));
    chk("b2b second pulses", 128'(rise_cnt), 128'(24));
    chk("b2b second mosi", mosi_acc, 128'(24'h8022_77));
    total++;
    if (last_gap >= 2) passed++;
    else $display("FAIL b2b cs_high_gap: got %0d expected >=2", last_gap);
    repeat (3) @(negedge clk);

    // Reset in the middle of a write, at the 10th SCLK pulse
    @(negedge clk);
    clear_obs();
    offer(1'b1, 2'b10, 6'h3F, 32'h1357_9BDF, "rst_mid", ok);
    tmo = 0;
    while (rise_cnt < 10 && tmo < TMO) begin @(negedge clk); tmo++; end
    chk("rst_mid reached_pulse10", 128'(rise_cnt), 128'(10));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid outputs", 128'({spi_cs_n, spi_clk, busy, rsp_valid, cmd_ready}), 128'(5'b10001));
    rst = 1'b0;
    repeat (600) @(negedge clk);
    chk("rst_mid no_rsp", 128'(rsp_cnt), 128'(0));
    run_txn(tbl[0].rw, tbl[0].width, tbl[0].addr, tbl[0].wdata, tbl[0].miso_word,
            tbl[0].exp_hdr, tbl[0].exp_pulses, tbl[0].exp_rdata, "after_rst");

    // Random traffic against the frame-level model
    for (int k = 0; k < 20; k++) begin
      logic rw; logic [1:0] w; logic [5:0] a; logic [31:0] d, word;
      int n;
      rw = 1'($urandom); w = 2'($urandom); a = 6'($urandom); d = $urandom; word = $urandom;
      n = n_of(w);
      run_txn(rw, w, a, d, word, hdr_of(rw, w, a), 16 + (rw ? 0 : READ_GAP) + n,
              rw ? 32'd0 : (word & mask_of(n)), $sformatf("rand%0d", k));
    end

    chk("mosi_stable_while_sclk_high", 128'(mosi_viol), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
